// File: rtl/usb_pkg.sv
// rtl/usb_pkg.sv - shared USB codes, PID constants and CRC16 helper
package usb_pkg;

    localparam int CLKS_PER_BIT_DEF = 9;

    typedef enum logic [2:0] {
        PKT_NONE  = 3'd0,
        PKT_DATA0 = 3'd1,
        PKT_DATA1 = 3'd2,
        PKT_ACK   = 3'd3,
        PKT_NAK   = 3'd4,
        PKT_STALL = 3'd5
    } packet_e;

    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    localparam logic [7:0]  SYNC_BYTE  = 8'h80;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_PID,
        ST_DATA,
        ST_CRC,
        ST_EOP_SE0,
        ST_EOP_J
    } tx_state_e;

    // PID byte on the wire carries the check nibble in the upper half
    function automatic logic [7:0] pid_byte(input packet_e pkt);
        logic [3:0] p;
        case (pkt)
            PKT_DATA0: p = PID_DATA0;
            PKT_DATA1: p = PID_DATA1;
            PKT_NAK:   p = PID_NAK;
            PKT_STALL: p = PID_STALL;
            default:   p = PID_ACK;
        endcase
        return {~p, p};
    endfunction

    function automatic logic [15:0] crc16_next(input logic [15:0] crc, input logic b);
        logic xr;
        xr = b ^ crc[15];
        return {crc[14] ^ xr, crc[13:2], crc[1] ^ xr, crc[0], xr};
    endfunction

endpackage

// File: rtl/usb_tx_encoder.sv
// rtl/usb_tx_encoder.sv - bit timer, bit stuffer, NRZI and SE0 line driver
module usb_tx_encoder
    import usb_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic clk,
    input  logic n_rst,
    input  logic bit_in,
    input  logic eop,
    input  logic stuff_en,
    input  logic strobe,
    output logic ready,
    output logic dp_out,
    output logic dm_out
);

    localparam int TW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

    logic [TW-1:0] timer;
    logic [2:0]    ones;
    logic          stuff_pending;

    // A new bit is accepted only once the current one has been held its full time
    assign ready = (timer == '0) && !stuff_pending;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            timer         <= '0;
            ones          <= '0;
            stuff_pending <= 1'b0;
            dp_out        <= 1'b1;
            dm_out        <= 1'b0;
        end else if (timer != '0) begin
            timer <= timer - 1'b1;
        end else if (stuff_pending) begin
            dp_out        <= ~dp_out;
            dm_out        <= ~dm_out;
            timer         <= LAST;
            stuff_pending <= 1'b0;
        end else if (strobe) begin
            timer <= LAST;
            if (eop) begin
                // bit_in selects J (1) or SE0 (0) during end of packet
                dp_out <= bit_in;
                dm_out <= 1'b0;
                ones   <= '0;
            end else begin
                if (!bit_in) begin
                    dp_out <= ~dp_out;
                    dm_out <= ~dm_out;
                end
                if (!stuff_en || !bit_in) begin
                    ones <= '0;
                end else if (ones == 3'd5) begin
                    ones          <= '0;
                    stuff_pending <= 1'b1;
                end else begin
                    ones <= ones + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/usb_tx.sv
// rtl/usb_tx.sv - full-speed USB device transmitter: packet FSM, payload fetch and CRC16
module usb_tx
    import usb_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [2:0] tx_packet,
    output logic       tx_transfer_active,
    output logic       get_tx_packet_data,
    input  logic [7:0] tx_packet_data,
    input  logic [6:0] buffer_occupancy,
    output logic       dp_out,
    output logic       dm_out
);

    tx_state_e   state, state_n;
    packet_e     pkt;
    logic [3:0]  bit_cnt;
    logic [7:0]  shift;
    logic [15:0] crc;

    logic       req_ok, is_data, have_byte;
    logic [7:0] pid_b;
    logic       strobe, bit_v, eop, stuff_en, ready;

    assign req_ok    = (tx_packet != 3'd0) && (tx_packet <= 3'd5);
    assign is_data   = (pkt == PKT_DATA0) || (pkt == PKT_DATA1);
    assign have_byte = (buffer_occupancy != 7'd0);
    assign pid_b     = pid_byte(pkt);

    assign tx_transfer_active = (state != ST_IDLE);

    always_comb begin
        state_n            = state;
        strobe             = 1'b0;
        bit_v              = 1'b1;
        eop                = 1'b0;
        stuff_en           = 1'b0;
        get_tx_packet_data = 1'b0;
        case (state)
            ST_IDLE: begin
                // first SYNC bit goes out on the same edge that accepts the request
                if (req_ok) begin
                    strobe  = 1'b1;
                    bit_v   = SYNC_BYTE[0];
                    state_n = ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (ready) begin
                    strobe = 1'b1;
                    bit_v  = SYNC_BYTE[bit_cnt[2:0]];
                    if (bit_cnt == 4'd7) state_n = ST_PID;
                end
            end
            ST_PID, ST_DATA: begin
                if (ready) begin
                    strobe   = 1'b1;
                    stuff_en = 1'b1;
                    bit_v    = (state == ST_PID) ? pid_b[bit_cnt[2:0]] : shift[bit_cnt[2:0]];
                    if (bit_cnt == 4'd7) begin
                        if (!is_data) begin
                            state_n = ST_EOP_SE0;
                        end else if (have_byte) begin
                            get_tx_packet_data = 1'b1;
                            state_n            = ST_DATA;
                        end else begin
                            state_n = ST_CRC;
                        end
                    end
                end
            end
            ST_CRC: begin
                if (ready) begin
                    strobe   = 1'b1;
                    stuff_en = 1'b1;
                    bit_v    = ~crc[15];
                    if (bit_cnt == 4'd15) state_n = ST_EOP_SE0;
                end
            end
            ST_EOP_SE0: begin
                if (ready) begin
                    strobe = 1'b1;
                    eop    = 1'b1;
                    bit_v  = 1'b0;
                    if (bit_cnt == 4'd1) state_n = ST_EOP_J;
                end
            end
            ST_EOP_J: begin
                // bit_cnt 0 launches the J bit, bit_cnt 1 waits for it to finish
                if (ready) begin
                    if (bit_cnt == 4'd0) begin
                        strobe = 1'b1;
                        eop    = 1'b1;
                        bit_v  = 1'b1;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= ST_IDLE;
            pkt     <= PKT_NONE;
            bit_cnt <= '0;
            shift   <= '0;
            crc     <= '0;
        end else begin
            state <= state_n;
            if (state == ST_IDLE) begin
                if (req_ok) begin
                    pkt     <= packet_e'(tx_packet);
                    bit_cnt <= 4'd1;
                    crc     <= CRC16_INIT;
                end
            end else begin
                if (state_n != state || get_tx_packet_data) begin
                    bit_cnt <= '0;
                end else if (strobe) begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
                if (strobe && state == ST_DATA) begin
                    crc <= crc16_next(crc, bit_v);
                end else if (strobe && state == ST_CRC) begin
                    crc <= {crc[14:0], 1'b0};
                end
            end
            if (get_tx_packet_data) shift <= tx_packet_data;
        end
    end

    usb_tx_encoder #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_encoder (
        .clk     (clk),
        .n_rst   (n_rst),
        .bit_in  (bit_v),
        .eop     (eop),
        .stuff_en(stuff_en),
        .strobe  (strobe),
        .ready   (ready),
        .dp_out  (dp_out),
        .dm_out  (dm_out)
    );

endmodule
